// File: rtl/operand_store_pkg.sv
// rtl/operand_store_pkg.sv - shared types and preset table for operand_store
// Preset arrays are only referenced when OPERAND_STORE_PRESET_EN is defined.
package operand_store_pkg;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int PRESET_N = 4;

  localparam logic [15:0] PRESET_A [PRESET_N] = '{16'h000A, 16'h0010, 16'h00FF, 16'h0030};
  localparam logic [15:0] PRESET_B [PRESET_N] = '{16'h0005, 16'h0008, 16'h000F, 16'h0010};

endpackage

// File: rtl/operand_store_bank.sv
// rtl/operand_store_bank.sv - one DEPTH x DATA_W operand bank (operand_bank)
// Single write port, registered read port, same-address write-to-read forwarding.
module operand_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Storage is not reset; the clear sweep initialises every entry.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (re) begin
      if (we && (waddr == raddr)) begin
        rd_data_d = wdata;
      end else begin
        rd_data_d = mem_q[raddr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/operand_store.sv
// rtl/operand_store.sv - two-bank writable operand store with clear sweep
// OPERAND_STORE_PRESET_EN: sweep loads the legacy preset pairs instead of all zeros.
module operand_store
  import operand_store_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  input  logic              wr_en,
  input  logic [1:0]        wr_mask,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic [DATA_W-1:0] wr_data_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              rd_valid_q, rd_valid_d;

  logic              we_a, we_b, re;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata_a, wdata_b;
  logic [DATA_W-1:0] sweep_a, sweep_b;

  always_comb begin
    sweep_a = '0;
    sweep_b = '0;
`ifdef OPERAND_STORE_PRESET_EN
    // Presets past the end of a small store are simply never matched.
    for (int i = 0; i < PRESET_N; i++) begin
      if ((i < DEPTH) && (int'(idx_q) == i)) begin
        sweep_a = DATA_W'(PRESET_A[i]);
        sweep_b = DATA_W'(PRESET_B[i]);
      end
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_valid_d = 1'b0;
    we_a       = 1'b0;
    we_b       = 1'b0;
    re         = 1'b0;
    waddr      = wr_addr;
    wdata_a    = wr_data_a;
    wdata_b    = wr_data_b;
    case (state_q)
      ST_SWEEP: begin
        if (clr) begin
          idx_d = '0;
        end else begin
          we_a    = 1'b1;
          we_b    = 1'b1;
          waddr   = idx_q;
          wdata_a = sweep_a;
          wdata_b = sweep_b;
          idx_d   = idx_q + 1'b1;
          if (&idx_q) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        // A clear pulse takes priority and drops any same-cycle access.
        if (clr) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end else begin
          we_a       = wr_en & wr_mask[0];
          we_b       = wr_en & wr_mask[1];
          re         = rd_req;
          rd_valid_d = rd_req;
        end
      end
      default: begin
        state_d = ST_SWEEP;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SWEEP;
      idx_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  operand_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we_a),
    .waddr   (waddr),
    .wdata   (wdata_a),
    .re      (re),
    .raddr   (rd_addr),
    .rd_data (a)
  );

  operand_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we_b),
    .waddr   (waddr),
    .wdata   (wdata_b),
    .re      (re),
    .raddr   (rd_addr),
    .rd_data (b)
  );

  assign busy     = (state_q == ST_SWEEP);
  assign rd_valid = rd_valid_q;

endmodule
